// File: rtl/spi_pkg.sv
// Shared types for the SPI master clock path: controller states, the
// {cpol,cpha} mode encoding and the default widths.
package spi_pkg;

  localparam int DEF_DIV_W = 8;
  localparam int DEF_CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_TAIL = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_e;

  function automatic logic mode_cpol(spi_mode_e m);
    logic [1:0] b;
    b = m;
    return b[1];
  endfunction

  function automatic logic mode_cpha(spi_mode_e m);
    logic [1:0] b;
    b = m;
    return b[0];
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period timer: counts 0..i_div while enabled and flags the terminal
// count with a one-cycle tick, restarting from zero afterwards.
module spi_tick_gen #(
  parameter int DIV_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Compare against i_div directly so the all-ones setting never wraps early.
  assign o_tick = i_en && (cnt_q == i_div);

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr || o_tick) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: gated SCLK with CPOL/CPHA, shift/sample
// strobes aligned to the SCLK edges, trailing hold half-period and abort.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_cpol,
  input  logic             i_cpha,
  input  logic [CNT_W-1:0] i_nbits,
  input  logic             i_start,
  input  logic             i_stop,
  output logic             o_sclk,
  output logic             o_busy,
  output logic             o_shift_stb,
  output logic             o_sample_stb,
  output logic             o_done
);

  state_e           state_q, state_d;
  spi_mode_e        mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] nbits_q, nbits_d;
  logic [CNT_W:0]   edge_q, edge_d, edge_nxt;
  logic             sclk_q, sclk_d;
  logic             shift_q, shift_d;
  logic             sample_q, sample_d;
  logic             tick, start_ok, leading, last_edge, cpol_l, cpha_l;

  assign start_ok  = i_start && (i_nbits != '0);
  assign cpol_l    = mode_cpol(mode_q);
  assign cpha_l    = mode_cpha(mode_q);
  // Edges are numbered from 1: odd numbers are leading, even are trailing.
  assign edge_nxt  = edge_q + (CNT_W + 1)'(1);
  assign leading   = edge_nxt[0];
  assign last_edge = (edge_nxt == {nbits_q, 1'b0});

  spi_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (state_q != ST_IDLE),
    .i_clr  (state_q == ST_IDLE),
    .i_div  (div_q),
    .o_tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    div_d    = div_q;
    nbits_d  = nbits_q;
    edge_d   = edge_q;
    sclk_d   = sclk_q;
    shift_d  = 1'b0;
    sample_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        sclk_d = i_cpol;
        edge_d = '0;
        if (start_ok) begin
          state_d = ST_RUN;
          mode_d  = spi_mode_e'({i_cpol, i_cpha});
          div_d   = i_div;
          nbits_d = i_nbits;
          // CPHA=0 must present the first bit before the first edge.
          shift_d = !i_cpha;
        end
      end
      ST_RUN: begin
        if (i_stop) begin
          state_d = ST_IDLE;
          sclk_d  = cpol_l;
        end else if (tick) begin
          sclk_d = !sclk_q;
          edge_d = edge_nxt;
          if (cpha_l) begin
            shift_d  = leading;
            sample_d = !leading;
          end else begin
            sample_d = leading;
            shift_d  = !leading && !last_edge;
          end
          if (last_edge) begin
            state_d = ST_TAIL;
          end
        end
      end
      ST_TAIL: begin
        if (i_stop) begin
          state_d = ST_IDLE;
          sclk_d  = cpol_l;
        end else if (tick) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE0;
      div_q    <= '0;
      nbits_q  <= '0;
      edge_q   <= '0;
      sclk_q   <= 1'b0;
      shift_q  <= 1'b0;
      sample_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      div_q    <= div_d;
      nbits_q  <= nbits_d;
      edge_q   <= edge_d;
      sclk_q   <= sclk_d;
      shift_q  <= shift_d;
      sample_q <= sample_d;
    end
  end

  assign o_sclk       = sclk_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_shift_stb  = shift_q;
  assign o_sample_stb = sample_q;
  assign o_done       = (state_q == ST_TAIL) && tick && !i_stop;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Randomised scoreboard bench for spi_sclk_gen: a per-cycle waveform model
// built from the transfer rules is queued at each start and compared by a monitor.
module tb_spi_sclk_gen;

  localparam int DIV_W = 8;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [DIV_W-1:0] i_div = '0;
  logic             i_cpol = 1'b0;
  logic             i_cpha = 1'b0;
  logic [CNT_W-1:0] i_nbits = '0;
  logic             i_start = 1'b0;
  logic             i_stop = 1'b0;
  logic             o_sclk, o_busy, o_shift_stb, o_sample_stb, o_done;
  logic [4:0]       outs;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic prev_cpol;

  typedef struct {
    int   cyc;
    logic [4:0] v;  // {busy, sclk, shift, sample, done}
  } exp_t;
  exp_t q[$];

  spi_sclk_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_div        (i_div),
    .i_cpol       (i_cpol),
    .i_cpha       (i_cpha),
    .i_nbits      (i_nbits),
    .i_start      (i_start),
    .i_stop       (i_stop),
    .o_sclk       (o_sclk),
    .o_busy       (o_busy),
    .o_shift_stb  (o_shift_stb),
    .o_sample_stb (o_sample_stb),
    .o_done       (o_done)
  );

  assign outs = {o_busy, o_sclk, o_shift_stb, o_sample_stb, o_done};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_cpol <= 1'b0;
    else        prev_cpol <= i_cpol;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cyc=%0d got(busy,sclk,sh,sa,dn)=%b expected=%b", nm, cyc, act, expv);
    end
  endtask

  // Monitor: scheduled cycles come from the queue; otherwise the DUT must be idle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("reset", outs, 5'b00000);
    end else if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk("xfer", outs, e.v);
    end else begin
      chk("idle", outs, {1'b0, prev_cpol, 3'b000});
    end
  end

  // Reference waveform: transfer accepted in cycle t0 (start sampled at its end).
  task automatic push_model(input int t0, input int d, input int n, input bit cpol, input bit cpha);
    int h, b, k, e;
    bit edge_ev, sh, sa, sclk;
    exp_t r;
    h = d + 1;
    b = (2 * n + 1) * h;
    for (int t = 1; t <= b; t++) begin
      k = (t - 1) / h;
      edge_ev = ((t - 1) % h == 0) && (k >= 1) && (k <= 2 * n);
      e = (k > 2 * n) ? 2 * n : k;
      sclk = cpol ^ (e % 2 == 1);
      if (cpha) begin
        sh = edge_ev && (k % 2 == 1);
        sa = edge_ev && (k % 2 == 0);
      end else begin
        sa = edge_ev && (k % 2 == 1);
        sh = (t == 1) || (edge_ev && (k % 2 == 0) && (k < 2 * n));
      end
      r.cyc = t0 + t;
      r.v = {1'b1, sclk, sh, sa, (t == b)};
      q.push_back(r);
    end
    r.cyc = t0 + b + 1;
    r.v = {1'b0, cpol, 3'b000};
    q.push_back(r);
  endtask

  // Runs one transfer; abort_at>0 raises i_stop in that cycle offset,
  // noise scrambles config/start inputs while busy.
  task automatic run_xfer(input int d, input int n, input bit cpol, input bit cpha,
                          input int abort_at, input bit noise);
    int t0, b, endc;
    exp_t r;
    t0 = cyc;
    b = (2 * n + 1) * (d + 1);
    i_div = DIV_W'(d);
    i_nbits = CNT_W'(n);
    i_cpol = cpol;
    i_cpha = cpha;
    i_start = 1'b1;
    i_stop = 1'b0;
    push_model(t0, d, n, cpol, cpha);
    endc = (abort_at > 0) ? t0 + abort_at + 1 : t0 + b + 1;
    @(posedge clk); #1;
    while (cyc < endc) begin
      i_start = 1'b0;
      i_stop = 1'b0;
      if (noise) begin
        i_start = 1'($urandom_range(0, 1));
        i_div = DIV_W'($urandom);
        i_cpol = 1'($urandom_range(0, 1));
        i_cpha = 1'($urandom_range(0, 1));
        i_nbits = CNT_W'($urandom);
      end
      if (cyc == t0 + b) begin
        i_start = 1'b1;
        i_nbits = CNT_W'(1);
      end
      if (abort_at > 0 && cyc == t0 + abort_at) begin
        i_stop = 1'b1;
        while (q.size() > 0 && q[q.size() - 1].cyc > cyc) void'(q.pop_back());
        r.cyc = cyc + 1;
        r.v = {1'b0, cpol, 3'b000};
        q.push_back(r);
      end
      @(posedge clk); #1;
    end
    i_start = 1'b0;
    i_stop = 1'b0;
  endtask

  task automatic idle_cycles(input int k, input bit noisy);
    repeat (k) begin
      if (noisy) begin
        i_cpol = 1'($urandom_range(0, 1));
        i_stop = 1'($urandom_range(0, 1));
        i_start = 1'($urandom_range(0, 1));
        i_nbits = '0;
      end
      @(posedge clk); #1;
    end
    i_start = 1'b0;
    i_stop = 1'b0;
  endtask

  initial begin
    int d, n, b, ab;
    bit cp, ch, nz;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(2, 1'b0);

    run_xfer(0, 8, 1'b0, 1'b0, 0, 1'b0);        // mode 0 basic
    i_cpol = 1'b1;
    idle_cycles(3, 1'b0);
    run_xfer(3, 4, 1'b1, 1'b1, 0, 1'b0);        // mode 3, divided
    i_cpol = 1'b0;
    idle_cycles(2, 1'b0);
    run_xfer(1, 8, 1'b0, 1'b1, 13, 1'b0);       // abort at 3rd sample strobe
    idle_cycles(2, 1'b0);
    i_nbits = '0;                                // start with nbits=0
    i_start = 1'b1;
    idle_cycles(1, 1'b0);
    idle_cycles(3, 1'b1);
    run_xfer(2, 5, 1'b0, 1'b0, 0, 1'b1);        // busy-time input noise
    run_xfer(1, 3, 1'b1, 1'b0, 0, 1'b0);        // back-to-back, 1-cycle gap

    // Asynchronous reset at the 5th edge of an 8-bit transfer.
    i_cpol = 1'b0;
    idle_cycles(2, 1'b0);
    begin
      int t0;
      t0 = cyc;
      i_div = '0; i_nbits = CNT_W'(8); i_cpha = 1'b0; i_start = 1'b1;
      push_model(t0, 0, 8, 1'b0, 1'b0);
      @(posedge clk); #1 i_start = 1'b0;
      while (cyc < t0 + 6) begin @(posedge clk); #1; end
      #1 rst_n = 1'b0;
      q.delete();
      #1 chk("async_reset", outs, 5'b00000);
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    end
    idle_cycles(2, 1'b0);
    run_xfer(0, 8, 1'b0, 1'b0, 0, 1'b0);        // normal after reset

    run_xfer(255, 1, 1'b0, 1'b1, 0, 1'b0);      // maximum divide

    for (int i = 0; i < 20; i++) begin
      d = $urandom_range(0, 4);
      n = $urandom_range(1, 31);
      cp = 1'($urandom_range(0, 1));
      ch = 1'($urandom_range(0, 1));
      nz = 1'($urandom_range(0, 1));
      b = (2 * n + 1) * (d + 1);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, b - 1) : 0;
      run_xfer(d, n, cp, ch, ab, nz);
      idle_cycles($urandom_range(0, 3), 1'b1);
    end

    idle_cycles(4, 1'b0);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_sclk_gen.md
# spi_sclk_gen

Programmable SPI serial-clock generator for the SPI master. It divides `i_clk` by an even, run-time ratio and emits `o_sclk` with selectable CPOL/CPHA. It gates the clock for an exact number of bit periods and produces single-cycle shift and sample strobes aligned to the SCLK edges for the shift-register datapath. It also adds a start/stop/done handshake and a trailing hold half-period, replacing the free-running power-of-two divider.

## Interface
- `DIV_W`, default 8: width of the half-period divide setting.
- `CNT_W`, default 5: width of the bit-count setting; max transfer is 2^CNT_W−1 bits.

Ports:
- `i_clk`, in, 1: system clock; all logic on its rising edge.
- `i_rst`, in, 1: reset, asynchronous, active-low.
- `i_div`, in, DIV_W: SCLK half-period = `i_div`+1 `i_clk` cycles.
- `i_cpol`, in, 1: SCLK idle level.
- `i_cpha`, in, 1:
  - 0 = sample on leading edge, shift on trailing.
  - 1 = shift on leading edge, sample on trailing.
- `i_nbits`, in, CNT_W: SCLK cycles (bits) per transfer; 0 is invalid.
- `i_start`, in, 1: start request, sampled only in IDLE.
- `i_stop`, in, 1: abort request.
- `o_sclk`, out, 1: serial clock, registered.
- `o_busy`, out, 1: transfer in progress.
- `o_shift_stb`, out, 1: one-cycle pulse; datapath launches the next bit.
- `o_sample_stb`, out, 1: one-cycle pulse; datapath captures MISO.
- `o_done`, out, 1: one-cycle pulse on normal completion.

## Operation
- **States:** IDLE, RUN, TAIL.
- **IDLE**
  - `o_sclk` = registered `i_cpol`, so an idle-polarity change appears one cycle later.
  - `i_start`=1 with `i_nbits`≠0 latches `i_div`, `i_cpol`, `i_cpha`, `i_nbits` and moves to RUN.
  - `i_start` with `i_nbits`=0 is ignored.
- **RUN**
  - Half-period counter counts 0..div_latched.
  - At terminal count: `o_sclk` toggles, edge counter increments, counter clears.
  - Odd edges are leading edges; even edges are trailing edges.
  - After edge 2·nbits, go to TAIL.
- **Strobes**
  - A strobe is high in the same cycle `o_sclk` shows the new level.
  - CPHA=0:
    - extra `o_shift_stb` in the first RUN cycle (first bit launched before the first edge);
    - `o_sample_stb` on every leading edge;
    - `o_shift_stb` on trailing edges 1..nbits−1, suppressed on the final trailing edge.
  - CPHA=1: `o_shift_stb` on every leading edge, `o_sample_stb` on every trailing edge.
  - Both modes: exactly nbits shift and nbits sample strobes per transfer.
- **TAIL**
  - One half-period (div+1 cycles) with `o_sclk` at idle, giving chip-select hold.
  - `o_done` pulses in the last TAIL cycle, then IDLE.
- **Ignored inputs while busy**
  - `i_start` is ignored.
  - Changes to the config inputs have no effect until the next start.
- **Abort**
  - `i_stop` in RUN/TAIL: next cycle IDLE, `o_sclk`=latched CPOL, `o_busy`=0.
  - No `o_done` and no further strobes.
  - `i_stop` beats a coinciding edge or done.
  - `i_stop` in IDLE is ignored.
- **Width rules**
  - Half-period counter is DIV_W bits; `i_div`=2^DIV_W−1 yields 2^DIV_W cycles with no overflow.
  - Edge counter is CNT_W+1 bits.

## Timing
- **Reset values:** `o_sclk`=0, `o_busy`=0, `o_shift_stb`=0, `o_sample_stb`=0, `o_done`=0, state IDLE, latched config 0.
- **Reset mid-transfer:** all outputs take reset values immediately (asynchronous); no done.
- **Start sequence:** start sampled in cycle T.
  - `o_busy`=1 from T+1.
  - First edge at T+1+(div+1).
- **Busy duration:** `o_busy` high for (2·nbits+1)·(div+1) cycles, with `o_done` in the last of them.
- **Back-to-back transfers:** minimum IDLE gap between transfers is 1 cycle (start in the done cycle is ignored).
- **SCLK duty:** exactly 50 %; period 2·(div+1) `i_clk` cycles.

## Structure
- **Shared package `spi_pkg`:**
  - state enum (IDLE/RUN/TAIL);
  - CPOL/CPHA mode encoding (mode = {cpol,cpha});
  - default widths `DIV_W`, `CNT_W`.
- **Sub-module `spi_tick_gen`:**
  - parameter DIV_W; inputs `i_clk`, `i_rst`, enable, clear, div;
  - one-cycle `tick` at terminal count;
  - the FSM, edge counter and strobe decode stay in `spi_sclk_gen`.

## Test plan
- **Mode 0, basic:** CPOL=0, CPHA=0, div=0, nbits=8.
  - busy 17 cycles, 8 rising edges, 8 sample strobes on rising edges;
  - shift strobes: first busy cycle plus 7 falling edges;
  - one done; sclk low after.
- **Mode 3, divided clock:** CPOL=1, CPHA=1, div=3, nbits=4.
  - idle high, 8-cycle SCLK period, busy 36 cycles;
  - 4 shift strobes on falling edges, 4 sample strobes on rising edges.
- **Abort:** mode 1, div=1, nbits=8; `i_stop` in the cycle of the 3rd sample strobe.
  - next cycle busy=0, sclk=0;
  - no done; exactly 3 sample strobes total.
- **Ignored inputs:**
  - start with nbits=0 → busy stays 0;
  - start during busy → no effect;
  - changing `i_div`, `i_cpol` mid-transfer → edge spacing and polarity unchanged.
- **Reset mid-transfer:** assert `i_rst` at edge 5 of nbits=8 → outputs 0 immediately; after release, a new start runs normally.
- **Maximum divide:** DIV_W=8, div=255, nbits=1 → half-period 256 cycles, busy 768 cycles, one sample strobe and one shift strobe.
